// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer FSM states and counter-width helper
package rst_seq_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RELEASE, RUN} state_t;
  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: lock/button inputs and staged reset outputs of the sequencer
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 2,
  parameter int LL_W        = 8
);
  logic                   pll_locked;
  logic                   btn_rst_n;
  logic [NUM_DOMAINS-1:0] rst_n_out;
  logic                   seq_done;
  logic [LL_W-1:0]        lock_loss_count;
  modport master(input pll_locked, btn_rst_n, output rst_n_out, seq_done, lock_loss_count);
  modport slave(output pll_locked, btn_rst_n, input rst_n_out, seq_done, lock_loss_count);
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: 2-FF synchroniser and debounce of an active-low button
module sync_debounce import rst_seq_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_n,
  output logic pressed
);
  localparam int W = clog2(DEBOUNCE_CYCLES);
  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q;
  logic         disagree;
  logic         flip;
  // synced level equal to pressed means the level opposes the debounced state
  assign disagree = sync_q[1] == pressed;
  assign flip     = disagree && cnt_q == W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      pressed <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din_n};
      cnt_q   <= (disagree && !flip) ? cnt_q + 1'b1 : '0;
      pressed <= flip ? ~pressed : pressed;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: lock/button-qualified staggered release of reset domains
module reset_sequencer import rst_seq_pkg::*; #(
  parameter int NUM_DOMAINS        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int BTN_EN             = 0,
  parameter int DEBOUNCE_CYCLES    = 12000,
  parameter int LL_W               = 8
) (
  input logic               clk,
  input logic               ext_rst_n,
  reset_sequencer_if.master bus
);
  localparam int STAB_W = clog2(LOCK_STABLE_CYCLES);
  localparam int GAP_W  = clog2(STAGE_GAP);
  localparam int STG_W  = clog2(NUM_DOMAINS);
  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [1:0]             lock_q;
  logic                   lock_sync;
  logic                   btn_raw;
  logic                   btn_pressed;
  logic                   fault;
  state_t                 state_q, state_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic [LL_W-1:0]        ll_q, ll_d;
  // reset asserts asynchronously, releases on clk
  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= '0;
    else lock_q <= {lock_q[0], bus.pll_locked};
  end
  assign lock_sync = lock_q[1];
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk),
    .rst_n(rst_n),
    .din_n(bus.btn_rst_n),
    .pressed(btn_raw)
  );
  assign btn_pressed = (BTN_EN != 0) && btn_raw;
  assign fault       = !lock_sync || btn_pressed;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      gap_q   <= '0;
      stage_q <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      ll_q    <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ll_q    <= ll_d;
    end
  end
  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    gap_d   = '0;
    stage_d = stage_q;
    rst_d   = rst_q;
    done_d  = done_q;
    ll_d    = ll_q;
    if (fault) begin
      state_d = WAIT_LOCK;
      stage_d = '0;
      rst_d   = '0;
      done_d  = 1'b0;
      ll_d    = (!lock_sync && (state_q == RELEASE || state_q == RUN) && ll_q != '1) ? ll_q + 1'b1 : ll_q;
    end else begin
      case (state_q)
        WAIT_LOCK: state_d = STABILIZE;
        STABILIZE: begin
          if (stab_q == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
            rst_d[0] = 1'b1;
            stage_d  = STG_W'(1);
            state_d  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            done_d   = (NUM_DOMAINS == 1);
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
            rst_d[stage_q] = 1'b1;
            stage_d        = stage_q + 1'b1;
            state_d        = (stage_q == STG_W'(NUM_DOMAINS - 1)) ? RUN : RELEASE;
            done_d         = (stage_q == STG_W'(NUM_DOMAINS - 1));
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.rst_n_out       = rst_q;
  assign bus.seq_done        = done_q;
  assign bus.lock_loss_count = ll_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release timing, faults, counter and async reset
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic ext_rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       done;
  } exp_t;
  exp_t tbl [6];
  reset_sequencer_if #(.NUM_DOMAINS(3), .LL_W(2)) bus ();
  reset_sequencer_if #(.NUM_DOMAINS(3), .LL_W(2)) bus0 ();
  reset_sequencer #(.NUM_DOMAINS(3), .LOCK_STABLE_CYCLES(8), .STAGE_GAP(4), .BTN_EN(1),
                    .DEBOUNCE_CYCLES(5), .LL_W(2)) dut (.clk(clk), .ext_rst_n(ext_rst_n), .bus(bus));
  reset_sequencer #(.NUM_DOMAINS(3), .LOCK_STABLE_CYCLES(8), .STAGE_GAP(4), .BTN_EN(0),
                    .DEBOUNCE_CYCLES(5), .LL_W(2)) dut0 (.clk(clk), .ext_rst_n(ext_rst_n), .bus(bus0));
  assign bus0.pll_locked = bus.pll_locked;
  assign bus0.btn_rst_n  = 1'b0;
  always #5 if (clk_en) clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input logic [2:0] r, input logic d);
    chk({name, "_rst"}, 32'(bus.rst_n_out), 32'(r));
    chk({name, "_done"}, 32'(bus.seq_done), 32'(d));
  endtask
  // edge 0 is the first posedge after the call; glitch_at drops pll_locked for that one edge
  task automatic run_seq(input int off, input int glitch_at, input bit both);
    for (int c = 0; c <= 18 + off; c++) begin
      @(negedge clk);
      if (c == glitch_at - 1) bus.pll_locked = 1'b0;
      if (c == glitch_at) bus.pll_locked = 1'b1;
      foreach (tbl[i]) begin
        if (tbl[i].cyc + off == c) begin
          chk_out($sformatf("seq_off%0d_c%0d", off, c), tbl[i].rst, tbl[i].done);
          if (both) begin
            chk($sformatf("nobtn_rst_c%0d", c), 32'(bus0.rst_n_out), 32'(tbl[i].rst));
            chk($sformatf("nobtn_done_c%0d", c), 32'(bus0.seq_done), 32'(tbl[i].done));
          end
        end
      end
    end
  endtask
  initial begin
    tbl = '{'{9, 3'b000, 1'b0}, '{10, 3'b001, 1'b0}, '{13, 3'b001, 1'b0},
            '{14, 3'b011, 1'b0}, '{17, 3'b011, 1'b0}, '{18, 3'b111, 1'b1}};
    bus.pll_locked = 1'b0;
    bus.btn_rst_n  = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("in_reset", 3'b000, 1'b0);
    chk("in_reset_cnt", 32'(bus.lock_loss_count), 0);
    ext_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("no_lock", 3'b000, 1'b0);
    bus.pll_locked = 1'b1;
    run_seq(0, -1, 1'b1);
    chk("powerup_cnt", 32'(bus.lock_loss_count), 0);
    bus.btn_rst_n = 1'b0;
    repeat (4) @(negedge clk);
    bus.btn_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_out("short_btn", 3'b111, 1'b1);
    bus.btn_rst_n = 1'b0;
    repeat (7) @(negedge clk);
    chk_out("btn_c6", 3'b111, 1'b1);
    @(negedge clk);
    chk_out("btn_c7", 3'b000, 1'b0);
    repeat (4) @(negedge clk);
    chk_out("btn_held", 3'b000, 1'b0);
    bus.btn_rst_n = 1'b1;
    run_seq(5, -1, 1'b0);
    chk("btn_cnt", 32'(bus.lock_loss_count), 0);
    bus.pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("loss_c1", 3'b111, 1'b1);
    @(negedge clk);
    chk_out("loss_c2", 3'b000, 1'b0);
    chk("loss1_cnt", 32'(bus.lock_loss_count), 1);
    repeat (3) @(negedge clk);
    bus.pll_locked = 1'b1;
    run_seq(7, 6, 1'b0);
    chk("glitch_cnt", 32'(bus.lock_loss_count), 1);
    bus.pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("loss2_cnt", 32'(bus.lock_loss_count), 2);
    repeat (2) @(negedge clk);
    bus.pll_locked = 1'b1;
    run_seq(0, -1, 1'b0);
    for (int i = 3; i <= 5; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      chk_out($sformatf("sat%0d", i), 3'b000, 1'b0);
      chk($sformatf("sat%0d_cnt", i), 32'(bus.lock_loss_count), 3);
      repeat (2) @(negedge clk);
      bus.pll_locked = 1'b1;
      repeat (20) @(negedge clk);
      chk_out($sformatf("sat%0d_run", i), 3'b111, 1'b1);
    end
    bus.pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    bus.pll_locked = 1'b1;
    repeat (12) @(negedge clk);
    chk_out("mid_release", 3'b001, 1'b0);
    clk_en = 1'b0;
    ext_rst_n = 1'b0;
    #1;
    chk_out("async_rst", 3'b000, 1'b0);
    chk("async_rst_cnt", 32'(bus.lock_loss_count), 0);
    #20;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    ext_rst_n = 1'b1;
    run_seq(2, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
